// File: rtl/rv_multicycle_sequencer.sv
// Multicycle RISC-V style control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with a timed memory handshake.
// Optional retire counter enabled by defining RV_SEQ_INSTRET_EN.
module rv_multicycle_sequencer #(
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int RESET_PC    = 0,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    input  logic                  mem_ack,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    output logic [WORD_SIZE-1:0]  instr,
    input  logic                  dec_is_load,
    input  logic                  dec_is_store,
    input  logic                  dec_is_branch,
    input  logic                  dec_illegal,
    input  logic [WORD_SIZE-1:0]  alu_result,
    input  logic [WORD_SIZE-1:0]  rv2,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  rf_we,
    output logic [WORD_SIZE-1:0]  rf_wdata,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  error,
    output logic [31:0]           instret
);

    localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] pc_r, pc_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic [WORD_SIZE-1:0]  instr_r, instr_s;
    logic [WORD_SIZE-1:0]  result_r, result_s;
    logic [WORD_SIZE-1:0]  load_data_r, load_data_s;
    logic [WORD_SIZE-1:0]  mem_wdata_r, mem_wdata_s;
    logic [WORD_SIZE-1:0]  rf_wdata_r, rf_wdata_s;
    logic [WAIT_W-1:0]     wait_cnt_r, wait_cnt_s;
    logic                  mem_req_r, mem_req_s;
    logic                  mem_we_r, mem_we_s;
    logic                  rf_we_r, rf_we_s;
    logic                  error_r, error_s;
    logic                  ack_s, in_req_state_s, timeout_s;

    function automatic logic writes_rf(input logic is_store, input logic is_branch);
        return !(is_store || is_branch);
    endfunction

    // Handshake qualification: an ack only counts while a request is actually on the bus.
    always_comb begin
        ack_s          = mem_ack & mem_req_r;
        in_req_state_s = (state_r == ST_FETCH) || (state_r == ST_MEM);
        timeout_s      = (ACK_TIMEOUT != 0) && in_req_state_s && !ack_s && (wait_cnt_r == WAIT_LAST);
    end

    // Next-state logic; any unencoded state falls into the terminal fault state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_START: state_s = ST_FETCH;
            ST_FETCH: begin
                if (ack_s) begin
                    state_s = ST_DECODE;
                end else if (timeout_s) begin
                    state_s = ST_ERROR;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_s = ST_ERROR;
                end else begin
                    state_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (dec_is_load || dec_is_store) begin
                    state_s = ST_MEM;
                end else begin
                    state_s = ST_WRITEBACK;
                end
            end
            ST_MEM: begin
                if (ack_s) begin
                    state_s = ST_WRITEBACK;
                end else if (timeout_s) begin
                    state_s = ST_ERROR;
                end else begin
                    state_s = ST_MEM;
                end
            end
            ST_WRITEBACK: state_s = ST_FETCH;
            ST_ERROR:     state_s = ST_ERROR;
            default:      state_s = ST_ERROR;
        endcase
    end

    // Datapath next values: instruction, ALU result, load data, pc and the ack wait counter.
    always_comb begin
        instr_s     = instr_r;
        result_s    = result_r;
        load_data_s = load_data_r;
        pc_s        = pc_r;
        wait_cnt_s  = wait_cnt_r;
        if ((state_r == ST_FETCH) && ack_s) begin
            instr_s = mem_rdata;
        end else begin
            instr_s = instr_r;
        end
        if (state_r == ST_EXECUTE) begin
            result_s = alu_result;
        end else begin
            result_s = result_r;
        end
        if ((state_r == ST_MEM) && ack_s && dec_is_load) begin
            load_data_s = mem_rdata;
        end else begin
            load_data_s = load_data_r;
        end
        if (state_r == ST_WRITEBACK) begin
            if (dec_is_branch && branch_taken) begin
                pc_s = branch_target;
            end else begin
                pc_s = pc_r + ADDR_WIDTH'(1);
            end
        end else begin
            pc_s = pc_r;
        end
        if ((ACK_TIMEOUT == 0) || !in_req_state_s || ack_s || (state_s != state_r)) begin
            wait_cnt_s = '0;
        end else begin
            wait_cnt_s = wait_cnt_r + WAIT_W'(1);
        end
    end

    // Output next values, derived from the upcoming state so every output leaves a flop.
    always_comb begin
        mem_req_s   = (state_s == ST_FETCH) || (state_s == ST_MEM);
        mem_we_s    = (state_s == ST_MEM) && dec_is_store;
        rf_we_s     = (state_s == ST_WRITEBACK) && writes_rf(dec_is_store, dec_is_branch);
        error_s     = (state_s == ST_ERROR);
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        rf_wdata_s  = rf_wdata_r;
        case (state_s)
            ST_FETCH: mem_addr_s = pc_s;
            ST_MEM: begin
                mem_addr_s  = result_s[ADDR_WIDTH-1:0];
                mem_wdata_s = rv2;
            end
            ST_WRITEBACK: begin
                if (dec_is_load) begin
                    rf_wdata_s = load_data_s;
                end else begin
                    rf_wdata_s = result_s;
                end
            end
            default: mem_addr_s = mem_addr_r;
        endcase
    end

    // State, pc and wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_START;
            pc_r       <= RESET_ADDR;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Internal datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_r     <= '0;
            result_r    <= '0;
            load_data_r <= '0;
        end else begin
            instr_r     <= instr_s;
            result_r    <= result_s;
            load_data_r <= load_data_s;
        end
    end

    // Registered memory, register-file and fault outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            rf_we_r     <= 1'b0;
            rf_wdata_r  <= '0;
            error_r     <= 1'b0;
        end else begin
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            rf_we_r     <= rf_we_s;
            rf_wdata_r  <= rf_wdata_s;
            error_r     <= error_s;
        end
    end

`ifdef RV_SEQ_INSTRET_EN
    logic [31:0] instret_r;

    // Retire counter: one count per WRITEBACK cycle, wrapping naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_r <= 32'd0;
        end else if (state_r == ST_WRITEBACK) begin
            instret_r <= instret_r + 32'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign instret = instret_r;
`else
    assign instret = 32'd0;
`endif

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign instr     = instr_r;
    assign rf_we     = rf_we_r;
    assign rf_wdata  = rf_wdata_r;
    assign pc        = pc_r;
    assign error     = error_r;

endmodule

// File: doc/rv_multicycle_sequencer.md
RV_MULTICYCLE_SEQUENCER -- requirements
Module: rv_multicycle_sequencer

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 32: datapath width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16: memory word-address width in bits.
REQ-003 The block SHALL have parameter RESET_PC, default 0: first fetch address.
REQ-004 The block SHALL have parameter ACK_TIMEOUT, default 15: maximum wait cycles for mem_ack; 0 disables the timeout.
REQ-005 The block SHALL have the following ports, clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable, valid with mem_req.
- mem_addr  out  ADDR_WIDTH  request address.
- mem_wdata  out  WORD_SIZE  store data.
- mem_ack  in  1  request accepted; read data valid this cycle.
- mem_rdata  in  WORD_SIZE  read data.
- instr  out  WORD_SIZE  latched instruction, fed to the external decoder.
- dec_is_load, dec_is_store, dec_is_branch, dec_illegal  in  1 each  decoder flags.
- alu_result  in  WORD_SIZE  ALU output.
- rv2  in  WORD_SIZE  register-file read value 2.
- branch_taken  in  1  branch condition.
- branch_target  in  ADDR_WIDTH  branch target address.
- rf_we  out  1  register-file write strobe.
- rf_wdata  out  WORD_SIZE  register-file write data.
- pc  out  ADDR_WIDTH  program counter.
- error  out  1  sticky fault flag.
- instret  out  32  retired-instruction count.

Function
REQ-006 The FSM SHALL have the states START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK and ERROR.
REQ-007 START SHALL last exactly 1 cycle and then go to FETCH.
REQ-008 In FETCH the block SHALL:
- assert mem_req=1, mem_we=0 and mem_addr=pc;
- hold these values stable until mem_ack is sampled high;
- on ack, latch mem_rdata into instr and go to DECODE.
REQ-009 A mem_ack in the same cycle as the first mem_req cycle (zero-wait) SHALL be accepted.
REQ-010 mem_ack SHALL be ignored when mem_req=0.
REQ-011 DECODE SHALL last 1 cycle; if dec_illegal=1 the next state SHALL be ERROR, otherwise EXECUTE.
REQ-012 EXECUTE SHALL last 1 cycle and latch alu_result into an internal result register.
REQ-013 From EXECUTE the next state SHALL be MEM if dec_is_load or dec_is_store is set, otherwise WRITEBACK.
REQ-014 In MEM the block SHALL:
- drive mem_req=1, mem_addr=result[ADDR_WIDTH-1:0], mem_we=dec_is_store and mem_wdata=rv2;
- use the same handshake as FETCH;
- on ack for a load, latch mem_rdata;
- then go to WRITEBACK.
REQ-015 WRITEBACK SHALL last 1 cycle and drive rf_we=1 unless the instruction is a store or a branch.
REQ-016 In WRITEBACK, rf_wdata SHALL be the loaded data for a load and the result register otherwise.
REQ-017 WRITEBACK SHALL update pc to branch_target if dec_is_branch and branch_taken are both 1, otherwise to pc+1 modulo 2^ADDR_WIDTH, and then go to FETCH.
REQ-018 rf_we SHALL be 0 in every state other than WRITEBACK.
REQ-019 mem_req SHALL be 0 in START, DECODE, EXECUTE, WRITEBACK and ERROR.
REQ-020 The minimum instruction latency SHALL be 4 cycles for ALU/branch instructions (FETCH..WRITEBACK with zero-wait ack) and 5 cycles for load/store.
REQ-021 With ACK_TIMEOUT=N>0, if mem_ack stays low for N consecutive mem_req cycles in FETCH or MEM, the next state SHALL be ERROR.
REQ-022 The wait counter SHALL clear on every ack and on every state entry.
REQ-023 ERROR SHALL be terminal until reset; in ERROR, error=1, mem_req=0 and rf_we=0.
REQ-024 Decoder inputs SHALL be sampled only in DECODE through WRITEBACK; their values in other states are don't-care.

Reset
REQ-025 Assertion of rst SHALL take effect immediately, regardless of state, including mid-handshake.
REQ-026 Under reset: state=START, pc=RESET_PC, instr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rf_we=0, rf_wdata=0, error=0, instret=0, wait counter=0.
REQ-027 An outstanding request SHALL be abandoned at reset; the memory side is required to tolerate a dropped mem_req.

Configuration
REQ-028 With macro RV_SEQ_INSTRET_EN defined, instret SHALL increment by 1, wrapping at 2^32, in every WRITEBACK cycle.
REQ-029 Without RV_SEQ_INSTRET_EN, instret SHALL be tied to 0 and the counter SHALL NOT be synthesised.

Verification
REQ-030 Zero-wait ALU instruction: rst released, ack tied high, decoder flags all 0, alu_result=0x5 -> rf_we pulses 1 cycle with rf_wdata=0x5 in cycle 4 after FETCH entry; pc 0->1.
REQ-031 Load with 3-cycle ack delay: dec_is_load=1, alu_result=0x20, mem_rdata=0xDEADBEEF -> MEM holds mem_addr=0x20 for 3 cycles; rf_wdata=0xDEADBEEF; rf_we=1 once.
REQ-032 Store: dec_is_store=1, rv2=0x1234, alu_result=0x40 -> mem_we=1, mem_wdata=0x1234, mem_addr=0x40; rf_we stays 0.
REQ-033 Taken branch at pc=0xFFFF with branch_target=0x10 -> pc=0x10; repeat with branch_taken=0 -> pc wraps to 0x0000.
REQ-034 Faults and reset:
- ack held low with ACK_TIMEOUT=15 -> error=1 after 15 request cycles, then mem_req=0 permanently;
- dec_illegal=1 -> ERROR directly from DECODE;
- rst pulsed mid-MEM -> all outputs at their reset values and a fetch from RESET_PC.
REQ-035 Retire counter: 10 instructions executed -> instret=10 with RV_SEQ_INSTRET_EN defined; instret=0 without it.
